timer_arbiter: RTL and testbench

TIMER_ARBITER -- requirements
Module: timer_arbiter

---
 rtl/timer_arb_pkg.sv | 10 +
 rtl/delay_counter.sv | 28 ++
 rtl/timer_arbiter.sv | 82 ++++++++
 tb/tb_timer_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_arb_pkg.sv
// timer_arb_pkg: shared defaults and FSM state encoding for the timer arbiter
package timer_arb_pkg;
  localparam int N_REQ_DEF = 4;
  localparam int CNT_W_DEF = 29;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/delay_counter.sv
// delay_counter: loadable down-counter whose terminal flag marks the last counting cycle
module delay_counter
  import timer_arb_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] val_i,
  output logic             term_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // a zero delay is stretched to one tick; decrement stops at 1 so the count never wraps
  always_comb begin
    cnt_d = clr_i ? '0
          : load_i ? ((val_i == '0) ? CNT_W'(1) : val_i)
          : (en_i && cnt_q > CNT_W'(1)) ? cnt_q - CNT_W'(1)
          : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign term_o = cnt_q == CNT_W'(1);
endmodule

// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin arbitration of one shared delay counter among N_REQ requesters
module timer_arbiter
  import timer_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int CNT_W = CNT_W_DEF,
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] ticks_in,
  input  logic [N_REQ-1:0]       cancel,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [GW-1:0]          grant_id
);
  state_e state_q, state_d;
  logic [GW-1:0] grant_q, grant_d, last_q, last_d, win, idx;
  logic [CNT_W-1:0] tk [N_REQ];
  logic load, en, clr, term;
  genvar i;
  for (i = 0; i < N_REQ; i++) begin : g_tk
    assign tk[i] = ticks_in[i*CNT_W +: CNT_W];
  end
  // scan downward so the requester nearest after last_q overrides all others
  always_comb begin
    win = last_q;
    idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = GW'((int'(last_q) + k) % N_REQ);
      if (req[idx]) win = idx;
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    load    = 1'b0;
    en      = 1'b0;
    clr     = 1'b0;
    case (state_q)
      S_IDLE: if (|req) begin
        state_d = S_COUNT;
        grant_d = win;
        last_d  = win;
        load    = 1'b1;
      end
      S_COUNT: if (cancel[grant_q] || !req[grant_q]) begin
        state_d = S_IDLE;
        clr     = 1'b1;
      end else if (term) begin
        state_d = S_DONE;
        clr     = 1'b1;
      end else en = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= GW'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end
  delay_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .load_i (load),
    .en_i   (en),
    .clr_i  (clr),
    .val_i  (tk[win]),
    .term_o (term)
  );
  assign done     = (state_q == S_DONE) ? N_REQ'(1) << grant_q : '0;
  assign busy     = state_q != S_IDLE;
  assign grant_id = grant_q;
endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: directed and randomized checks of timer_arbiter against a deadline-based model
module tb_timer_arbiter;
  localparam int N = 4;
  localparam int W = 29;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] cancel = '0;
  logic [N*W-1:0] ticks_in = '0;
  logic [N-1:0] done;
  logic busy;
  logic [1:0] grant_id;
  int total = 0;
  int bad = 0;
  bit m_owned, m_pulse;
  int m_owner, m_last;
  longint cyc = 0;
  longint m_deadline;

  timer_arbiter #(.N_REQ(N), .CNT_W(W)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .ticks_in(ticks_in),
    .cancel(cancel), .done(done), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] exp_done();
    return m_pulse ? N'(1) << m_owner : '0;
  endfunction

  // owner finishes at an absolute edge number: grant edge + max(ticks,1)
  task automatic tick();
    longint t;
    bit found;
    @(posedge clk);
    cyc++;
    if (!reset_n) begin
      m_owned = 0; m_pulse = 0; m_owner = 0; m_last = N - 1;
    end else if (m_pulse) begin
      m_pulse = 0; m_owned = 0;
    end else if (m_owned) begin
      if (cancel[m_owner] || !req[m_owner]) m_owned = 0;
      else if (cyc == m_deadline) m_pulse = 1;
    end else if (|req) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && req[(m_last + k) % N]) begin
          m_owner = (m_last + k) % N;
          found = 1;
        end
      end
      t = longint'(ticks_in[m_owner*W +: W]);
      m_deadline = cyc + ((t == 0) ? 1 : t);
      m_last = m_owner;
      m_owned = 1;
    end
    #1;
  endtask

  task automatic set_t(input int i, input longint t);
    ticks_in[i*W +: W] = W'(t);
  endtask

  task automatic do_reset();
    reset_n = 0; req = '0; cancel = '0;
    tick(); tick();
    reset_n = 1;
  endtask

  task automatic test_reset();
    reset_n = 0; req = '1; cancel = '1;
    for (int i = 0; i < N; i++) set_t(i, 2);
    tick(); tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 4'b0) begin bad++; $display("FAIL reset_done got=%b exp=0000", done); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_gid got=%0d exp=0", grant_id); end
    reset_n = 1; req = '0; cancel = '0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle got=%b exp=0", busy); end
  endtask

  task automatic test_single();
    int n;
    do_reset();
    set_t(0, 5); req = 4'b0001;
    tick();
    total++; if (busy !== 1'b1 || grant_id !== 2'd0) begin bad++; $display("FAIL single_grant busy=%b gid=%0d exp busy=1 gid=0", busy, grant_id); end
    n = 0;
    while (done === 4'b0 && n < 20) begin tick(); n++; end
    total++; if (n !== 5) begin bad++; $display("FAIL single_latency got=%0d exp=5", n); end
    total++; if (done !== 4'b0001) begin bad++; $display("FAIL single_done got=%b exp=0001", done); end
    req = '0;
    tick();
    total++; if (done !== 4'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_width done=%b busy=%b exp 0000/0", done, busy); end
  endtask

  task automatic test_contention();
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    longint g_edge, prev_g;
    bit prev_busy;
    do_reset();
    for (int i = 0; i < N; i++) set_t(i, 3);
    req = 4'b1111;
    prev_busy = 0; g_edge = 0;
    for (int c = 0; c < 40 && order.size() < 5; c++) begin
      tick();
      if (busy && !prev_busy) begin
        prev_g = g_edge; g_edge = cyc;
        if (order.size() > 0) begin
          total++; if (g_edge - prev_g !== 5) begin bad++; $display("FAIL cont_spacing got=%0d exp=5", g_edge - prev_g); end
        end
        order.push_back(int'(grant_id));
      end
      if (done !== 4'b0) begin
        total++; if (cyc - g_edge !== 3) begin bad++; $display("FAIL cont_latency got=%0d exp=3", cyc - g_edge); end
        total++; if (done !== N'(1) << order[order.size()-1]) begin bad++; $display("FAIL cont_done got=%b owner=%0d", done, order[order.size()-1]); end
      end
      prev_busy = busy;
    end
    total++; if (order.size() !== 5) begin bad++; $display("FAIL cont_count got=%0d exp=5", order.size()); end
    for (int i = 0; i < 5 && i < order.size(); i++) begin
      total++; if (order[i] !== exp_order[i]) begin bad++; $display("FAIL cont_order idx=%0d got=%0d exp=%0d", i, order[i], exp_order[i]); end
    end
    req = '0; tick(); tick();
  endtask

  task automatic test_abort();
    bit saw;
    do_reset();
    set_t(2, 10); req = 4'b0100;
    tick();
    total++; if (grant_id !== 2'd2) begin bad++; $display("FAIL abort_gid got=%0d exp=2", grant_id); end
    tick();
    cancel = 4'b0010;
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_nonowner busy got=%b exp=1", busy); end
    cancel = '0;
    tick();
    cancel = 4'b0100;
    tick();
    total++; if (busy !== 1'b0 || done !== 4'b0) begin bad++; $display("FAIL abort_idle busy=%b done=%b exp 0/0000", busy, done); end
    cancel = '0; req = '0;
    saw = 0;
    for (int c = 0; c < 15; c++) begin tick(); saw |= (done !== 4'b0); end
    total++; if (saw !== 1'b0) begin bad++; $display("FAIL abort_nodone got=1 exp=0"); end
    set_t(0, 4); req = 4'b0001; cancel = 4'b0001;
    tick();
    total++; if (busy !== 1'b1 || grant_id !== 2'd0) begin bad++; $display("FAIL abort_idlecancel busy=%b gid=%0d exp 1/0", busy, grant_id); end
    cancel = '0; req = '0; tick(); tick();
  endtask

  task automatic test_zero_latch();
    int n;
    do_reset();
    set_t(0, 0); req = 4'b0001;
    tick(); tick();
    total++; if (done !== 4'b0001) begin bad++; $display("FAIL zero_done got=%b exp=0001", done); end
    req = '0; tick(); tick();
    set_t(1, 8); req = 4'b0010;
    tick();
    total++; if (grant_id !== 2'd1) begin bad++; $display("FAIL latch_gid got=%0d exp=1", grant_id); end
    tick(); tick();
    set_t(1, 2);
    tick();
    set_t(1, 100);
    n = 3;
    while (done === 4'b0 && n < 30) begin tick(); n++; end
    total++; if (n !== 8) begin bad++; $display("FAIL latch_latency got=%0d exp=8", n); end
    req = '0; tick(); tick();
  endtask

  task automatic test_reset_mid();
    bit saw;
    do_reset();
    for (int i = 0; i < N; i++) set_t(i, 8);
    req = 4'b0100;
    tick(); saw = 0;
    tick(); saw |= (done !== 4'b0);
    tick(); saw |= (done !== 4'b0);
    reset_n = 0;
    tick();
    total++; if (busy !== 1'b0 || done !== 4'b0 || grant_id !== 2'd0) begin bad++; $display("FAIL rstmid_outputs busy=%b done=%b gid=%0d exp 0/0000/0", busy, done, grant_id); end
    reset_n = 1; req = 4'b1111;
    tick();
    total++; if (busy !== 1'b1 || grant_id !== 2'd0) begin bad++; $display("FAIL rstmid_first busy=%b gid=%0d exp 1/0", busy, grant_id); end
    total++; if (saw !== 1'b0) begin bad++; $display("FAIL rstmid_nodone got=1 exp=0"); end
    req = '0; tick(); tick();
  endtask

  task automatic test_long();
    bit saw, all_busy;
    do_reset();
    set_t(0, 500000000); req = 4'b0001;
    saw = 0; all_busy = 1;
    for (int c = 0; c < 300; c++) begin tick(); saw |= (done !== 4'b0); all_busy &= (busy === 1'b1); end
    total++; if (saw !== 1'b0 || all_busy !== 1'b1) begin bad++; $display("FAIL long_hold saw_done=%b all_busy=%b exp 0/1", saw, all_busy); end
    req = '0; tick(); tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      cancel = ($urandom_range(0, 9) == 0) ? N'(1) << $urandom_range(0, N - 1) : '0;
      for (int i = 0; i < N; i++) set_t(i, longint'($urandom_range(0, 6)));
      reset_n = ($urandom_range(0, 199) != 0);
      tick();
      total++; if (busy !== m_owned) begin bad++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, busy, m_owned); end
      total++; if (done !== exp_done()) begin bad++; $display("FAIL rand_done cyc=%0d got=%b exp=%b", cyc, done, exp_done()); end
      total++; if (grant_id !== 2'(m_owner)) begin bad++; $display("FAIL rand_gid cyc=%0d got=%0d exp=%0d", cyc, grant_id, m_owner); end
    end
    reset_n = 1; req = '0; cancel = '0; tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_abort();
    test_zero_latch();
    test_reset_mid();
    test_long();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
